freq_meter_multi: RTL
=====================

Name: freq_meter_multi

Overview:
- Multi-channel gated event counter: counts single-cycle event strobes per channel over a measurement window, latches results, then reports them.
- Generalises the per-clock PPS counters in the top level to NCH channels.
- Adds an internal or external gate source, continuous or single-shot mode, saturation/overflow, and external-gate-loss detection.
- Event strobes arrive already synchronised into aclk, e.g. from flag_sync. Results feed a VIO or a wishbone register bank.

Parameters:
- NCH, 4, number of event channels (1..16).
- CNTBITS, 32, counter/result width per channel.
- GATE_CYCLES, 100000000, internal gate period in aclk cycles (>=2).
- LOSS_CYCLES, 2*GATE_CYCLES, external gate timeout in aclk cycles.

Ports:
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- event_i  in  NCH  per-channel event strobes, one count per high cycle.
- ext_gate_i  in  1  external window-boundary strobe (e.g. PPS), single-cycle.
- gate_sel_i  in  1  0 = internal gate counter, 1 = ext_gate_i.
- mode_i  in  1  0 = continuous, 1 = single-shot.
- arm_i  in  1  single-shot start strobe.
- count_o  out  NCH*CNTBITS  latched counts, channel k at [k*CNTBITS +: CNTBITS].
- ovf_o  out  NCH  per-channel saturation flag for the latched window.
- valid_o  out  1  one-cycle pulse when count_o/ovf_o update.
- busy_o  out  1  high while armed or counting.
- gate_lost_o  out  1  sticky: external gate missing for LOSS_CYCLES.

Behaviour:
- Reset: count_o=0, ovf_o=0, valid_o=0, busy_o=0, gate_lost_o=0, state IDLE, all counters 0.
- Boundary strobe (bnd):
  - Internal: a gate counter runs 0..GATE_CYCLES-1 and asserts bnd when it wraps.
  - External: bnd = ext_gate_i.
  - The gate counter restarts at 0 on entry to WAIT and runs only in WAIT/COUNT.
- IDLE:
  - Continuous mode: go to WAIT.
  - Single-shot mode: stay in IDLE until arm_i, then go to WAIT.
  - busy_o=0.
- WAIT (busy_o=1):
  - Discard events.
  - On bnd, go to COUNT; each channel counter loads event_i[k] (0/1) and its ovf clears.
- COUNT (busy_o=1):
  - Each cycle, a channel counter increments if event_i[k].
  - At all-ones the counter holds and sets its ovf (saturation, no wrap).
  - On bnd:
    - Count_o and ovf_o take the counters next cycle; valid_o pulses on that same cycle. Latency = 1 cycle from bnd.
    - The event on the bnd cycle belongs to the new window: the counter reloads event_i[k], ovf clears.
    - Continuous mode: stay in COUNT.
    - Single-shot mode: go to IDLE.
- Window length: count_o equals the events in the GATE_CYCLES cycles (internal) or the cycles between consecutive strobes (external). No events are lost or double counted across back-to-back windows.
- Mode or gate_sel change mid-window: takes effect at the next IDLE/WAIT decision. The current window completes in its original configuration. Exception: a gate_sel change forces the FSM to WAIT without latching.
- arm_i outside IDLE: ignored. arm_i in continuous mode: ignored.
- gate_lost_o:
  - The loss counter increments only in WAIT/COUNT with gate_sel_i=1.
  - It clears on ext_gate_i.
  - When it reaches LOSS_CYCLES, gate_lost_o sets. The FSM stays in its current state, with no forced latch.
  - gate_lost_o clears only on reset or when arm_i arrives while in IDLE.
- ext_gate_i simultaneous with arm_i in IDLE: arm is taken. The strobe is not a boundary, because the FSM is not in WAIT that cycle.
- Reset mid-window: all state returns to the reset values immediately (asynchronous), with no valid_o pulse.
- Reset implementation: deassertion is assumed externally synchronised; all flops use async clear.

Decomposition:
- freq_meter_pkg:
  - state enum: IDLE, WAIT, COUNT.
  - MODE_CONT / MODE_SINGLE constants.
  - GATE_INT / GATE_EXT constants.
  - function clog2-based width helpers for the gate and loss counters.
- Sub-module freq_meter_chan: one saturating counter plus latched result/ovf per channel, with load/inc/latch controls. It is instantiated NCH times in a generate loop. The top module holds the FSM, gate counter and loss counter.

Test Plan:
- Internal gate, GATE_CYCLES=100, continuous, event_i[0] high every cycle, event_i[1] every 4th cycle.
  - Required: every window gives count0=100, count1=25.
  - valid_o pulses every 100 cycles, one cycle after bnd.
- External gate, strobes 50 cycles apart, event_i[2] constant high, single-shot, arm_i once.
  - Required: exactly one valid_o, count2=50, busy_o back to 0, and no further updates.
- CNTBITS=4, 30 events in one window.
  - Required: count=15, ovf bit=1.
  - The next window with 3 events gives count=3, ovf=0.
- Event asserted exactly on the bnd cycle.
  - Required: that event is counted in the new window, not the old one (sum across windows equals total events).
- gate_sel_i=1, no ext_gate_i for LOSS_CYCLES=200.
  - Required: gate_lost_o rises at cycle 200 and stays set.
  - A later arm_i in IDLE clears it.
- aresetn pulled low mid-COUNT.
  - Required: outputs go to 0 at once, with no valid_o.
  - After release in continuous mode, the first valid_o comes only after a full WAIT plus one full window.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants and width helpers for the multi-channel gated event counter.
package freq_meter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

   localparam logic GATE_INT = 1'b0;
   localparam logic GATE_EXT = 1'b1;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/freq_meter_chan.sv
// One channel: saturating event counter plus the result/overflow latched at each window end.
module freq_meter_chan #(
   parameter int CNTBITS = 32
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               load,
   input  logic               inc,
   input  logic               latch,
   input  logic               ev,
   output logic [CNTBITS-1:0] count_o,
   output logic               ovf_o
);

   logic [CNTBITS-1:0] cnt;
   logic               sat;

   // Latch sees the pre-reload value, so the boundary-cycle event starts the new window.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt     <= '0;
         sat     <= 1'b0;
         count_o <= '0;
         ovf_o   <= 1'b0;
      end else begin
         if (latch) begin
            count_o <= cnt;
            ovf_o   <= sat;
         end
         if (load) begin
            cnt <= CNTBITS'(ev);
            sat <= 1'b0;
         end else if (inc && ev) begin
            if (&cnt) sat <= 1'b1;
            else      cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/freq_meter_multi.sv
// Multi-channel gated event counter: FSM, internal gate counter and external-gate loss
// detection; per-channel counting lives in freq_meter_chan.
module freq_meter_multi
   import freq_meter_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int CNTBITS     = 32,
   parameter int GATE_CYCLES = 100000000,
   parameter int LOSS_CYCLES = 2 * GATE_CYCLES
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NCH-1:0]         event_i,
   input  logic                   ext_gate_i,
   input  logic                   gate_sel_i,
   input  logic                   mode_i,
   input  logic                   arm_i,
   output logic [NCH*CNTBITS-1:0] count_o,
   output logic [NCH-1:0]         ovf_o,
   output logic                   valid_o,
   output logic                   busy_o,
   output logic                   gate_lost_o,
   output logic [1:0]             dbg_state
);

   localparam int GW = cnt_width(GATE_CYCLES);
   localparam int LW = cnt_width(LOSS_CYCLES + 1);

   logic [1:0]    state, state_nxt;
   logic [GW-1:0] gate_cnt;
   logic [LW-1:0] loss_cnt;
   logic          sel_q, mode_q;
   logic          active, sel_chg, gate_wrap, bnd, latch, arm_idle;

   assign active    = (state == ST_WAIT) || (state == ST_COUNT);
   assign sel_chg   = active && (gate_sel_i != sel_q);
   assign gate_wrap = (gate_cnt == GW'(GATE_CYCLES - 1));
   assign bnd       = active && !sel_chg && ((sel_q == GATE_EXT) ? ext_gate_i : gate_wrap);
   assign latch     = bnd && (state == ST_COUNT);
   assign arm_idle  = (state == ST_IDLE) && arm_i;
   assign busy_o    = active;
   assign dbg_state = state;

   // A gate source change abandons the open window and re-synchronises in WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (mode_i == MODE_CONT || arm_i) state_nxt = ST_WAIT;
         ST_WAIT:  if (bnd) state_nxt = ST_COUNT;
         ST_COUNT: begin
            if (sel_chg)                              state_nxt = ST_WAIT;
            else if (bnd && mode_q == MODE_SINGLE)    state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         sel_q    <= GATE_INT;
         mode_q   <= MODE_CONT;
         gate_cnt <= '0;
         valid_o  <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_o <= latch;
         if (!active || sel_chg) sel_q <= gate_sel_i;
         // Mode is captured at each window start so a window ends in the mode it began with.
         if (bnd) mode_q <= mode_i;
         if (!active || sel_chg || gate_wrap) gate_cnt <= '0;
         else                                 gate_cnt <= gate_cnt + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         loss_cnt    <= '0;
         gate_lost_o <= 1'b0;
      end else begin
         if (ext_gate_i || arm_idle)
            loss_cnt <= '0;
         else if (active && gate_sel_i && loss_cnt != LW'(LOSS_CYCLES))
            loss_cnt <= loss_cnt + 1'b1;

         if (arm_idle)
            gate_lost_o <= 1'b0;
         else if (active && gate_sel_i && !ext_gate_i && loss_cnt == LW'(LOSS_CYCLES - 1))
            gate_lost_o <= 1'b1;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      freq_meter_chan #(.CNTBITS(CNTBITS)) u_chan (
         .aclk    (aclk),
         .aresetn (aresetn),
         .load    (bnd),
         .inc     (state == ST_COUNT),
         .latch   (latch),
         .ev      (event_i[k]),
         .count_o (count_o[k*CNTBITS +: CNTBITS]),
         .ovf_o   (ovf_o[k])
      );
   end

endmodule
